ctr_drbg_generate: RTL and testbench

// - CTR_DRBG (AES-256, no derivation function) generate engine; the consumer/reader of the working state the update core writes.
// - Holds working Key/V/reseed counter, produces nblocks x 128-bit outputs AES(Key,V+i), then drives the update core with additional input.
// - Sits between the DRBG top-level command decoder and the shared AES-256 core and update core.

---
 rtl/ctr_drbg_pkg.sv | 18 +
 rtl/ctr_drbg_generate.sv | 157 +++++++++++++++
 tb/tb_ctr_drbg_generate.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctr_drbg_pkg.sv
// Shared CTR_DRBG (AES-256, no df) constants and generate-engine state encoding.
package ctr_drbg_pkg;
  localparam int KEYLEN   = 256;
  localparam int BLOCKLEN = 128;
  localparam int SEEDLEN  = 384;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE_UPD,
    ST_PRE_WAIT,
    ST_AES_GO,
    ST_AES_WAIT,
    ST_OUT_HOLD,
    ST_POST_UPD,
    ST_POST_WAIT,
    ST_DONE
  } gen_state_e;
endpackage

// File: rtl/ctr_drbg_generate.sv
// CTR_DRBG generate engine: emits nblocks of AES(Key,V+i) and then refreshes Key/V via the update core.
// Latency excluding AES/update/sink stalls: 1 accept cycle + 2 per block + 2.
// Backpressure: a block is held on out_data_o until out_ready_i; no further AES is started meanwhile.
module ctr_drbg_generate
  import ctr_drbg_pkg::*;
#(
  parameter int               NB_W            = 8,
  parameter int               CNT_W           = 49,
  parameter logic [CNT_W-1:0] RESEED_INTERVAL = CNT_W'(1) << 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_load_i,
  input  logic [KEYLEN-1:0]   inst_key_i,
  input  logic [BLOCKLEN-1:0] inst_v_i,
  input  logic                gen_req_i,
  output logic                gen_ready_o,
  input  logic [NB_W-1:0]     gen_nblocks_i,
  input  logic [SEEDLEN-1:0]  gen_addin_i,
  output logic                gen_done_o,
  output logic                gen_err_o,
  output logic                reseed_req_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [BLOCKLEN-1:0] out_data_o,
  output logic                out_last_o,
  output logic                aes_start_o,
  output logic [KEYLEN-1:0]   aes_key_o,
  output logic [BLOCKLEN-1:0] aes_pt_o,
  input  logic                aes_done_i,
  input  logic [BLOCKLEN-1:0] aes_ct_i,
  output logic                upd_start_o,
  output logic [SEEDLEN-1:0]  upd_data_o,
  output logic [KEYLEN-1:0]   upd_key_o,
  output logic [BLOCKLEN-1:0] upd_v_o,
  input  logic                upd_done_i,
  input  logic [KEYLEN-1:0]   upd_key_i,
  input  logic [BLOCKLEN-1:0] upd_v_i
);

  gen_state_e          state_q, state_d;
  logic [KEYLEN-1:0]   key_q;
  logic [BLOCKLEN-1:0] v_q;
  logic [BLOCKLEN-1:0] ct_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                inst_q;
  logic [SEEDLEN-1:0]  addin_q;
  logic [NB_W-1:0]     nblk_q;
  logic [NB_W-1:0]     blk_q;
  logic                err_q;
  logic                aes_start_q;
  logic                accept;
  logic                reject;
  logic                last_blk;

  // A load in the same cycle as a request takes priority, so ready drops.
  assign gen_ready_o  = (state_q == ST_IDLE) && !inst_load_i;
  assign accept       = gen_req_i && gen_ready_o;
  assign reseed_req_o = !inst_q || (cnt_q > RESEED_INTERVAL);
  assign reject       = reseed_req_o || (gen_nblocks_i == '0);
  assign last_blk     = (blk_q == nblk_q);

  assign gen_done_o  = (state_q == ST_DONE);
  assign gen_err_o   = (state_q == ST_DONE) && err_q;
  assign out_valid_o = (state_q == ST_OUT_HOLD);
  assign out_last_o  = (state_q == ST_OUT_HOLD) && last_blk;
  assign out_data_o  = ct_q;
  assign aes_start_o = aes_start_q;
  assign aes_key_o   = key_q;
  assign aes_pt_o    = v_q;
  assign upd_start_o = (state_q == ST_PRE_UPD) || (state_q == ST_POST_UPD);
  assign upd_data_o  = addin_q;
  assign upd_key_o   = key_q;
  assign upd_v_o     = v_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (reject)                state_d = ST_DONE;
          else if (gen_addin_i != '0) state_d = ST_PRE_UPD;
          else                       state_d = ST_AES_GO;
        end
      end
      ST_PRE_UPD:   state_d = ST_PRE_WAIT;
      ST_PRE_WAIT:  if (upd_done_i) state_d = ST_AES_GO;
      ST_AES_GO:    state_d = ST_AES_WAIT;
      ST_AES_WAIT:  if (aes_done_i) state_d = ST_OUT_HOLD;
      ST_OUT_HOLD:  if (out_ready_i) state_d = last_blk ? ST_POST_UPD : ST_AES_GO;
      ST_POST_UPD:  state_d = ST_POST_WAIT;
      ST_POST_WAIT: if (upd_done_i) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q       <= '0;
      v_q         <= '0;
      ct_q        <= '0;
      cnt_q       <= '0;
      inst_q      <= 1'b0;
      addin_q     <= '0;
      nblk_q      <= '0;
      blk_q       <= '0;
      err_q       <= 1'b0;
      aes_start_q <= 1'b0;
    end else begin
      // Registered so the pulse coincides with the already-incremented V.
      aes_start_q <= (state_q == ST_AES_GO);
      case (state_q)
        ST_IDLE: begin
          if (inst_load_i) begin
            key_q  <= inst_key_i;
            v_q    <= inst_v_i;
            cnt_q  <= CNT_W'(1);
            inst_q <= 1'b1;
          end else if (accept) begin
            err_q <= reject;
            if (!reject) begin
              addin_q <= gen_addin_i;
              nblk_q  <= gen_nblocks_i;
              blk_q   <= '0;
            end
          end
        end
        ST_PRE_WAIT: begin
          if (upd_done_i) begin
            key_q <= upd_key_i;
            v_q   <= upd_v_i;
          end
        end
        ST_AES_GO: begin
          v_q   <= v_q + BLOCKLEN'(1);
          blk_q <= blk_q + NB_W'(1);
        end
        ST_AES_WAIT: if (aes_done_i) ct_q <= aes_ct_i;
        ST_POST_WAIT: begin
          if (upd_done_i) begin
            key_q <= upd_key_i;
            v_q   <= upd_v_i;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctr_drbg_generate.sv
// Scoreboarded bench for ctr_drbg_generate with an XOR AES stand-in and a behavioural update core.
module tb_ctr_drbg_generate;
  import ctr_drbg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, inst_load, gen_req, gen_ready, gen_done, gen_err, reseed_req;
  logic [255:0]        inst_key;
  logic [127:0]        inst_v;
  logic [7:0]          gen_nblocks;
  logic [383:0]        gen_addin;
  logic                out_valid, sink_rdy, out_last;
  logic [127:0]        out_data;
  logic                aes_start, aes_done;
  logic [255:0]        aes_key;
  logic [127:0]        aes_pt, aes_ct;
  logic                upd_start, upd_done;
  logic [383:0]        upd_data;
  logic [255:0]        upd_key_o, upd_key_i;
  logic [127:0]        upd_v_o, upd_v_i;

  ctr_drbg_generate #(.NB_W(8), .CNT_W(49), .RESEED_INTERVAL(49'd2)) dut (
    .clk(clk), .rst(rst),
    .inst_load_i(inst_load), .inst_key_i(inst_key), .inst_v_i(inst_v),
    .gen_req_i(gen_req), .gen_ready_o(gen_ready), .gen_nblocks_i(gen_nblocks),
    .gen_addin_i(gen_addin), .gen_done_o(gen_done), .gen_err_o(gen_err),
    .reseed_req_o(reseed_req),
    .out_valid_o(out_valid), .out_ready_i(sink_rdy), .out_data_o(out_data), .out_last_o(out_last),
    .aes_start_o(aes_start), .aes_key_o(aes_key), .aes_pt_o(aes_pt),
    .aes_done_i(aes_done), .aes_ct_i(aes_ct),
    .upd_start_o(upd_start), .upd_data_o(upd_data), .upd_key_o(upd_key_o), .upd_v_o(upd_v_o),
    .upd_done_i(upd_done), .upd_key_i(upd_key_i), .upd_v_i(upd_v_i)
  );

  int vecs = 0;
  int errs = 0;
  int aes_cnt = 0;
  logic [383:0] q_aes[$];   // {key, pt}
  logic [383:0] q_upd[$];   // provided_data
  logic [128:0] q_out[$];   // {last, data}
  logic         q_done[$];  // expected gen_err_o

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    vecs++;
    errs++;
    $display("FAIL %s: event not expected or never arrived", name);
  endtask

  // AES stand-in: ct = pt ^ key[127:0], done 3 cycles after start.
  int aes_dly;
  always @(posedge clk) begin
    aes_done <= 1'b0;
    if (rst) aes_dly <= 0;
    else if (aes_start) begin
      aes_ct  <= aes_pt ^ aes_key[127:0];
      aes_dly <= 3;
    end else if (aes_dly > 0) begin
      aes_dly <= aes_dly - 1;
      if (aes_dly == 1) aes_done <= 1'b1;
    end
  end

  function automatic logic [383:0] upd_fn(input logic [383:0] d, input logic [255:0] k,
                                          input logic [127:0] v);
    logic [383:0] t;
    logic [127:0] vv;
    vv = v;
    t  = '0;
    for (int i = 0; i < 3; i++) begin
      vv = vv + 128'd1;
      t[383-128*i -: 128] = vv ^ k[127:0];
    end
    return t ^ d;
  endfunction

  int upd_dly;
  logic [383:0] upd_res;
  assign upd_key_i = upd_res[383:128];
  assign upd_v_i   = upd_res[127:0];
  always @(posedge clk) begin
    upd_done <= 1'b0;
    if (rst) begin
      upd_dly <= 0;
      upd_res <= '0;
    end else if (upd_start) begin
      upd_res <= upd_fn(upd_data, upd_key_o, upd_v_o);
      upd_dly <= 4;
    end else if (upd_dly > 0) begin
      upd_dly <= upd_dly - 1;
      if (upd_dly == 1) upd_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (aes_start) begin
        aes_cnt++;
        if (q_aes.size() == 0) unexpected("aes_start");
        else check("aes_key_pt", {aes_key, aes_pt}, q_aes.pop_front());
      end
      if (upd_start) begin
        if (q_upd.size() == 0) unexpected("upd_start");
        else check("upd_data", upd_data, q_upd.pop_front());
      end
      if (out_valid && sink_rdy) begin
        if (q_out.size() == 0) unexpected("out_valid");
        else check("out_last_data", {out_last, out_data}, q_out.pop_front());
      end
      if (gen_done) begin
        if (q_done.size() == 0) unexpected("gen_done");
        else check("gen_err", gen_err, q_done.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [255:0] k, input logic [127:0] v);
    inst_load = 1'b1;
    inst_key  = k;
    inst_v    = v;
    tick();
    inst_load = 1'b0;
  endtask

  task automatic issue(input logic [7:0] nb, input logic [383:0] ad);
    gen_req     = 1'b1;
    gen_nblocks = nb;
    gen_addin   = ad;
    tick();
    gen_req = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (gen_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) unexpected("gen_done_timeout");
    tick();
  endtask

  task automatic drained(input string name);
    check(name, q_aes.size() + q_upd.size() + q_out.size() + q_done.size(), 0);
  endtask

  int c0;
  bit seen;
  logic [383:0] addin_a;

  initial begin
    rst = 1'b1; inst_load = 1'b0; gen_req = 1'b0; sink_rdy = 1'b1;
    inst_key = '0; inst_v = '0; gen_nblocks = '0; gen_addin = '0;
    repeat (3) tick();
    check("rst_ready", gen_ready, 1'b1);
    check("rst_reseed_req", reseed_req, 1'b1);
    check("rst_pulses", {out_valid, gen_done, aes_start, upd_start}, 4'b0);
    check("rst_data", {out_data, aes_pt, aes_key}, '0);
    rst = 1'b0;
    tick();

    // Uninstantiated request is rejected without touching AES.
    q_done.push_back(1'b1);
    issue(8'd1, '0);
    wait_done();
    check("uninst_reseed_req", reseed_req, 1'b1);
    drained("uninst_drained");

    // Zero block count is rejected.
    load('0, '0);
    check("loaded_reseed_req", reseed_req, 1'b0);
    q_done.push_back(1'b1);
    issue(8'd0, '0);
    wait_done();
    drained("nb0_drained");

    // Key=0, V=0x0F, two blocks, no additional input.
    load('0, 128'h0F);
    q_aes.push_back({256'h0, 128'h10});
    q_aes.push_back({256'h0, 128'h11});
    q_out.push_back({1'b0, 128'h10});
    q_out.push_back({1'b1, 128'h11});
    q_upd.push_back('0);
    q_done.push_back(1'b0);
    issue(8'd2, '0);
    wait_done();
    drained("two_blk_drained");

    // V wraps from all-ones to zero.
    load('0, '1);
    q_aes.push_back({256'h0, 128'h0});
    q_out.push_back({1'b1, 128'h0});
    q_upd.push_back('0);
    q_done.push_back(1'b0);
    issue(8'd1, '0);
    wait_done();
    drained("wrap_drained");

    // Additional input: pre-update gives Key={A1,B2}, V=C3; pt=C4, ct=C4^B2=76.
    addin_a = {128'hA0, 128'hB0, 128'hC0};
    load('0, '0);
    q_upd.push_back(addin_a);
    q_upd.push_back(addin_a);
    q_aes.push_back({128'hA1, 128'hB2, 128'hC4});
    q_out.push_back({1'b1, 128'h76});
    q_done.push_back(1'b0);
    issue(8'd1, addin_a);
    wait_done();
    drained("addin_drained");

    // Reseed interval of 2: third call fails until the next load.
    load('0, '0);
    q_aes.push_back({256'h0, 128'h1});
    q_out.push_back({1'b1, 128'h1});
    q_upd.push_back('0);
    q_done.push_back(1'b0);
    issue(8'd1, '0);
    wait_done();
    check("call1_reseed_req", reseed_req, 1'b0);
    q_aes.push_back({128'h2, 128'h3, 128'h5});
    q_out.push_back({1'b1, 128'h6});
    q_upd.push_back('0);
    q_done.push_back(1'b0);
    issue(8'd1, '0);
    wait_done();
    check("call2_reseed_req", reseed_req, 1'b1);
    q_done.push_back(1'b1);
    issue(8'd1, '0);
    wait_done();
    check("call3_reseed_req", reseed_req, 1'b1);
    load('0, '0);
    check("reload_reseed_req", reseed_req, 1'b0);
    q_aes.push_back({256'h0, 128'h1});
    q_out.push_back({1'b1, 128'h1});
    q_upd.push_back('0);
    q_done.push_back(1'b0);
    issue(8'd1, '0);
    wait_done();
    drained("reseed_drained");

    // Load and request together: load wins, nothing is accepted.
    inst_load = 1'b1; inst_key = '0; inst_v = '0;
    gen_req = 1'b1; gen_nblocks = 8'd1; gen_addin = '0;
    @(negedge clk);
    check("load_req_ready", gen_ready, 1'b0);
    tick();
    inst_load = 1'b0; gen_req = 1'b0;
    repeat (5) tick();
    check("load_req_idle", gen_ready, 1'b1);
    drained("load_req_drained");

    // Sink stall holds the block and blocks the next AES start.
    load('0, '0);
    sink_rdy = 1'b0;
    q_aes.push_back({256'h0, 128'h1});
    q_aes.push_back({256'h0, 128'h2});
    q_out.push_back({1'b0, 128'h1});
    q_out.push_back({1'b1, 128'h2});
    q_upd.push_back('0);
    q_done.push_back(1'b0);
    issue(8'd2, '0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) unexpected("stall_out_valid_timeout");
    c0 = aes_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_hold", {out_valid, out_data}, {1'b1, 128'h1});
    end
    check("stall_no_aes", aes_cnt, c0);
    tick();
    sink_rdy = 1'b1;
    wait_done();
    drained("stall_drained");

    // Reset while waiting on AES aborts everything.
    load('0, '0);
    q_aes.push_back({256'h0, 128'h1});
    c0 = aes_cnt;
    issue(8'd1, '0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (aes_cnt != c0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) unexpected("rst_aes_start_timeout");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", gen_ready, 1'b1);
    check("midrst_outputs", {out_valid, gen_done, aes_start, upd_start}, 4'b0);
    check("midrst_reseed_req", reseed_req, 1'b1);
    repeat (10) tick();
    drained("midrst_drained");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
